// File: rtl/slow_to_fast_xfer_if.sv
// Bundle of the capture inputs, the FIFO drain handshake and the status outputs
// of slow_to_fast_xfer. The master side is the system around the block.
interface slow_to_fast_xfer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int RATIO_WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   valid_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   ready_in;
    logic                   valid_out;
    logic [DATA_WIDTH-1:0]  data_out;
    logic [CW-1:0]          fifo_count;
    logic                   overflow;
    logic                   slow_edge;
    logic [RATIO_WIDTH-1:0] ratio;
    logic                   ratio_valid;

    modport master (
        output valid_in, data_in, ready_in,
        input  valid_out, data_out, fifo_count, overflow, slow_edge, ratio, ratio_valid
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output valid_out, data_out, fifo_count, overflow, slow_edge, ratio, ratio_valid
    );
endinterface

// File: rtl/slow_to_fast_xfer.sv
// Moves words from a slow, phase-related clock domain into clk_fast by sampling
// clk_slow as data, capturing on its rising edge into a FWFT FIFO, and measuring the clock ratio.
module slow_to_fast_xfer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 1,
    parameter int RATIO_WIDTH = 8
) (
    input  logic             clk_fast,
    input  logic             reset,
    input  logic             clk_slow,
    slow_to_fast_xfer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [RATIO_WIDTH-1:0] RATIO_MAX = '1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    function automatic logic [RATIO_WIDTH-1:0] sat_inc(input logic [RATIO_WIDTH-1:0] v);
        return (v == RATIO_MAX) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] samp_p0;
    logic [SYNC_STAGES-1:0] vld_p0;
    logic                   prev_p1;
    logic                   armed;
    logic                   edge_det;

    // Stage p0: clk_slow sampling chain. vld_p0 marks bits holding a real sample, so the
    // reset value of the chain can never be mistaken for a low clk_slow when arming.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            samp_p0 <= '0;
            vld_p0  <= '0;
            prev_p1 <= 1'b0;
            armed   <= 1'b0;
        end else begin
            samp_p0[0] <= clk_slow;
            vld_p0[0]  <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                samp_p0[i] <= samp_p0[i-1];
                vld_p0[i]  <= vld_p0[i-1];
            end
            prev_p1 <= samp_p0[SYNC_STAGES-1];
            if (vld_p0[SYNC_STAGES-1] && !samp_p0[SYNC_STAGES-1])
                armed <= 1'b1;
        end
    end

    // Stage p1: rising-edge decision, only once a genuine low level has been observed.
    assign edge_det = armed & samp_p0[SYNC_STAGES-1] & ~prev_p1;

    logic                   slow_edge_p2;
    logic [RATIO_WIDTH-1:0] period_cnt;
    logic                   seen_edge;
    logic [RATIO_WIDTH-1:0] ratio_p2;
    logic                   ratio_vld_p2;

    // Stage p2: edge pulse and period measurement, updated on the same edge.
    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            slow_edge_p2 <= 1'b0;
            period_cnt   <= '0;
            seen_edge    <= 1'b0;
            ratio_p2     <= '0;
            ratio_vld_p2 <= 1'b0;
        end else begin
            slow_edge_p2 <= edge_det;
            if (edge_det) begin
                period_cnt <= RATIO_WIDTH'(1);
                seen_edge  <= 1'b1;
                if (seen_edge) begin
                    ratio_p2     <= period_cnt;
                    ratio_vld_p2 <= 1'b1;
                end
            end else begin
                period_cnt <= sat_inc(period_cnt);
            end
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  wr_en;

    assign push  = edge_det & bus.valid_in;
    assign full  = (count == COUNT_FULL);
    assign pop   = (count != '0) & bus.ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (wr_en)
            mem[wr_ptr] <= bus.data_in;
    end

    assign bus.valid_out   = (count != '0);
    assign bus.data_out    = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.fifo_count  = count;
    assign bus.overflow    = overflow_q;
    assign bus.slow_edge   = slow_edge_p2;
    assign bus.ratio       = ratio_p2;
    assign bus.ratio_valid = ratio_vld_p2;
endmodule
